fifo_buffer: RTL and testbench
==============================

# fifo_buffer

Parametrised synchronous first-word-fall-through FIFO: the buffering successor to the library's single-entry enabled register. Stores up to DEPTH words of WIDTH bits with push/pop strobes, full/empty/almost-full status, an occupancy count and sticky overflow/underflow error flags. It sits between a producer and consumer running on the same clock, such as datapath stages or I/O capture and processing logic.

## Interface
- WIDTH, 8: data word width in bits (≥1).
- DEPTH, 8: number of entries; power of two, ≥2.
- ALMOST_FULL, DEPTH-1: count threshold at which almost_full asserts (1..DEPTH).
- RESET_VAL, '0: value driven on rd_data while empty.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; highest priority after reset_n.
- push  input  1  write strobe.
- wr_data  input  WIDTH  data written on an accepted push.
- pop  input  1  read strobe; consumes the current head.
- rd_data  output  WIDTH  head entry (FWFT), or RESET_VAL when empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ ALMOST_FULL.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a push was dropped.
- underflow  output  1  sticky: a pop was dropped.

## Operation
- Storage is a DEPTH×WIDTH array. Write and read pointers are each $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2·DEPTH.
- Accept rules, evaluated each edge:
  - Pop is accepted when !empty.
  - Push is accepted when !full, or when full and pop is also accepted in the same cycle (simultaneous push+pop on full: both proceed, count unchanged).
  - Push+pop on empty: push accepted, pop dropped (underflow sets), count becomes 1.
- A dropped push sets overflow; a dropped pop sets underflow. Both flags stay set until clear or reset.
- count updates by +1 (push only), −1 (pop only) or 0 (both or neither), using accepted operations only.
- clear: pointers, count, overflow and underflow go to 0. Any push/pop in the same cycle is ignored. Array contents are not cleared.
- reset_n low, asynchronously: same effect as clear. The array is not reset.
- rd_data is combinational from array[rd_ptr] when !empty, else RESET_VAL. It is never X after reset.

## Timing
- Values under reset: empty=1, full=0, almost_full=0 (or 1 only if ALMOST_FULL is 0, which is illegal), count=0, overflow=0, underflow=0, rd_data=RESET_VAL.
- Write-to-read latency is 1 cycle. A push accepted at edge N makes the word visible on rd_data, and deasserts empty, immediately after edge N.
- Pop at edge N: rd_data shows the next entry after edge N.
- Status outputs (full, empty, almost_full, count, flags) are registered or derived from registers only. No combinational path from push or pop to any status output.
- No combinational path from push or wr_data to rd_data.
- Reset asserted mid-burst aborts all in-flight state immediately. The first push after reset_n rises lands at entry 0.
- Deassertion of reset_n is assumed synchronised externally.

## Structure
- Package fifo_pkg holds the localparams PTR_W = $clog2(DEPTH) and CNT_W = PTR_W+1, plus a typedef for the pointer/count type. Parameter legality checks (DEPTH power of two, ALMOST_FULL range) are elaboration-time assertions in the package or top.
- One sub-module, fifo_ptr, implements a wrapping pointer counter. It has clock, reset_n, clear and inc inputs and a CNT_W-bit ptr output, and is instantiated twice (read and write).
- The array, accept logic, count and flags live in fifo_buffer.

## Test plan
- Reset then idle → empty=1, count=0, rd_data=RESET_VAL, flags 0.
- WIDTH=8, DEPTH=4:
  - Push 0x11,0x22,0x33,0x44 → full=1, count=4, rd_data=0x11. Then push 0x55 → overflow=1, contents unchanged.
  - Pop 4× → rd_data sequence 0x11,0x22,0x33,0x44, then empty=1 and rd_data=RESET_VAL. Then pop again → underflow=1.
  - With FIFO full, push 0x66 + pop together → count stays 4, head becomes 0x22, 0x66 is last out.
  - Wrap test: 10 interleaved push/pop pairs of 0xA0..0xA9 → output order preserved and count never exceeds 1.
- Clear and reset_n during a burst:
  - Assert clear with count=3 and push=1 → count=0, flags 0, push ignored.
  - Pulse reset_n low mid-burst, between edges → outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the fifo_buffer slice.
//   DEF_DEPTH  default FIFO depth
//   PTR_W      index width into the storage array for the default depth
//   CNT_W      pointer/count width; the extra MSB is the wrap bit
//   ptr_t      pointer/count type for the default configuration
//   is_pow2()  legality helper used at elaboration
package fifo_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int PTR_W     = $clog2(DEF_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef logic [CNT_W-1:0] ptr_t;

  // True for powers of two that are at least 2.
  function automatic bit is_pow2(input int unsigned v);
    return (v >= 32'd2) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping pointer counter for one side of the FIFO.
//   clock    posedge clock
//   reset_n  asynchronous active-low reset, pointer -> 0
//   clear    synchronous flush, pointer -> 0 (wins over inc)
//   inc      advance the pointer by one
//   ptr      CNT_W-bit pointer; wraps modulo 2**CNT_W (= 2*DEPTH)
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int CW = CNT_W
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] ptr
);

  logic [CW-1:0] ptr_r;

  // Pointer register: reset, flush, or advance on an accepted operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= '0;
    end else if (clear) begin
      ptr_r <= '0;
    end else if (inc) begin
      ptr_r <= ptr_r + CW'(1);
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer: synchronous first-word-fall-through FIFO.
//   clock        posedge clock
//   reset_n      asynchronous active-low reset (array contents kept)
//   clear        synchronous flush; push/pop in the same cycle are ignored
//   push/wr_data write strobe and data
//   pop          read strobe, consumes the current head
//   rd_data      head entry, or RESET_VAL while empty
//   full/empty/almost_full/count  occupancy status, register-derived
//   overflow/underflow            sticky dropped-push / dropped-pop flags
module fifo_buffer
  import fifo_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = DEF_DEPTH,
  parameter int               ALMOST_FULL = DEPTH - 1,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int            PW    = $clog2(DEPTH);
  localparam int            CW    = PW + 1;
  localparam logic [CW-1:0] AF_TH = CW'(ALMOST_FULL);

  // Parameter legality, checked at elaboration.
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("fifo_buffer: DEPTH must be a power of two >= 2");
  end
  if ((ALMOST_FULL < 1) || (ALMOST_FULL > DEPTH)) begin : g_bad_af
    $error("fifo_buffer: ALMOST_FULL must be in 1..DEPTH");
  end

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    wr_ptr_s;
  logic [CW-1:0]    rd_ptr_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             almost_full_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             empty_s;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             wr_inc_s;
  logic             rd_inc_s;

  // Wrap-bit encoding: equal pointers mean empty, same index with
  // opposite wrap bits means full.
  assign empty_s = (wr_ptr_s == rd_ptr_s);
  assign full_s  = (wr_ptr_s[PW-1:0] == rd_ptr_s[PW-1:0]) &&
                   (wr_ptr_s[PW] != rd_ptr_s[PW]);

  // Accept logic. A full FIFO is never empty, so a push on full rides
  // along with the pop that frees the slot in the same cycle.
  assign pop_ok_s  = pop  && !empty_s;
  assign push_ok_s = push && (!full_s || pop_ok_s);
  assign wr_inc_s  = push_ok_s && !clear;
  assign rd_inc_s  = pop_ok_s  && !clear;

  fifo_ptr #(.CW(CW)) u_wr_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .inc     (wr_inc_s),
    .ptr     (wr_ptr_s)
  );

  fifo_ptr #(.CW(CW)) u_rd_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .inc     (rd_inc_s),
    .ptr     (rd_ptr_s)
  );

  // Storage write; the array is deliberately never reset or flushed.
  always_ff @(posedge clock) begin
    if (wr_inc_s) begin
      mem_r[wr_ptr_s[PW-1:0]] <= wr_data;
    end
  end

  // Next occupancy from accepted operations only.
  always_comb begin
    count_next_s = count_r;
    unique case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Occupancy, almost-full and sticky error flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r       <= '0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
      underflow_r   <= 1'b0;
    end else if (clear) begin
      count_r       <= '0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
      underflow_r   <= 1'b0;
    end else begin
      count_r       <= count_next_s;
      almost_full_r <= (count_next_s >= AF_TH);
      overflow_r    <= overflow_r  || (push && !push_ok_s);
      underflow_r   <= underflow_r || (pop  && !pop_ok_s);
    end
  end

  // FWFT head: depends only on pointers and array, never on push/wr_data.
  always_comb begin
    if (empty_s) begin
      rd_data = RESET_VAL;
    end else begin
      rd_data = mem_r[rd_ptr_s[PW-1:0]];
    end
  end

  assign full        = full_s;
  assign empty       = empty_s;
  assign almost_full = almost_full_r;
  assign count       = count_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed plus randomized bench for fifo_buffer (WIDTH=8,
// DEPTH=4, ALMOST_FULL=3, RESET_VAL=8'hEE) against a queue-based model.
module tb_fifo_buffer;

  localparam int         W   = 8;
  localparam int         D   = 4;
  localparam int         AF  = 3;
  localparam logic [7:0] RV  = 8'hEE;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         clear;
  logic         push;
  logic [W-1:0] wr_data;
  logic         pop;
  logic [W-1:0] rd_data;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic [2:0]   count;
  logic         overflow;
  logic         underflow;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model: contents as a queue plus the two sticky flags.
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_unf;

  fifo_buffer #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL(AF), .RESET_VAL(RV)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (clear),
    .push        (push),
    .wr_data     (wr_data),
    .pop         (pop),
    .rd_data     (rd_data),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock edge of the FIFO rules applied to the queue.
  task automatic model_step(input bit p, input logic [7:0] d, input bit po, input bit cl);
    bit pop_ok;
    bit push_ok;
    if (cl) begin
      model_reset();
    end else begin
      pop_ok  = po && (mq.size() > 0);
      push_ok = p && ((mq.size() < D) || pop_ok);
      if (pop_ok)  void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
      if (p && !push_ok) m_ovf = 1'b1;
      if (po && !pop_ok) m_unf = 1'b1;
    end
  endtask

  // Drive one cycle's strobes, let the edge happen, advance the model.
  task automatic cycle(input bit p, input logic [7:0] d, input bit po, input bit cl);
    push = p; wr_data = d; pop = po; clear = cl;
    @(posedge clock);
    model_step(p, d, po, cl);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0;
  endtask

  // Per-cycle compare of every output against the model, away from the edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("rd_data",     rd_data,     (mq.size() > 0) ? mq[0] : RV);
      check("count",       count,       mq.size());
      check("full",        full,        mq.size() == D);
      check("empty",       empty,       mq.size() == 0);
      check("almost_full", almost_full, mq.size() >= AF);
      check("overflow",    overflow,    m_ovf);
      check("underflow",   underflow,   m_unf);
    end
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; wr_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 3'd0);
    check("rst_rd",    rd_data, 8'hEE);
    check("rst_flags", {overflow, underflow, full, almost_full}, 4'b0000);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill, then overflow.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    check("first_rd", rd_data, 8'h11);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    check("af_at3", almost_full, 1'b1);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    check("full4", {full, count}, {1'b1, 3'd4});
    check("head11", rd_data, 8'h11);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    check("ovf", {overflow, count}, {1'b1, 3'd4});

    // Drain in order, then underflow.
    cycle(1'b0, 8'h00, 1'b1, 1'b0); check("pop1", rd_data, 8'h22);
    cycle(1'b0, 8'h00, 1'b1, 1'b0); check("pop2", rd_data, 8'h33);
    cycle(1'b0, 8'h00, 1'b1, 1'b0); check("pop3", rd_data, 8'h44);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drained", {empty, rd_data}, {1'b1, 8'hEE});
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf", underflow, 1'b1);

    // Simultaneous push+pop on full.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 1'b1, 1'b0);
    check("pp_full", {count, rd_data}, {3'd4, 8'h22});
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("pp_empty", empty, 1'b1);

    // Wrap: interleaved push/pop keeps order and count <= 1.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      check("wrap_head", {count, rd_data}, {3'd1, 8'hA0 + 8'(i)});
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Push+pop on empty: push lands, pop is dropped.
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    check("pp_empty_cnt", {count, rd_data}, {3'd1, 8'h77});

    // Clear with count=3 and a push in the same cycle.
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    check("pre_clear", count, 3'd3);
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    check("clear", {count, overflow, underflow, empty}, {3'd0, 1'b0, 1'b0, 1'b1});

    // Asynchronous reset mid-burst, between edges.
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b1, 8'h5B, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1 == 1'b0);
    cycle(1'b1, 8'h5C, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst", {empty, count, rd_data, overflow, underflow}, {1'b1, 3'd0, 8'hEE, 1'b0, 1'b0});
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    check("post_rst", {count, rd_data}, {3'd1, 8'hC3});

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0));
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
